// File: rtl/jt12_mmr_wrq.sv
// jt12_mmr_wrq: queued CPU write front end for the FM register file.
// Address-port writes update a shadow register/bank; data-port writes push
// {bank, reg, data} into a circular queue that a small FSM drains as
// single-cycle strobes separated by a programmable hold time.
module jt12_mmr_wrq #(
  parameter int DEPTH    = 8,
  parameter int BANKS    = 2,
  parameter int HOLD     = 32,
  parameter int HOLD_KON = 64,
  parameter int CW       = 8,
  localparam int AW = 1 + $clog2(BANKS),
  localparam int BW = (AW > 1) ? AW - 1 : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [7:0]    din,
  input  logic [AW-1:0] addr,
  input  logic          write,
  input  logic          flush,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          wr_stb,
  output logic [BW-1:0] wr_bank,
  output logic [7:0]    wr_reg,
  output logic [7:0]    wr_data,
  output logic [CW-1:0] ovf_cnt
);

  localparam int PW   = $clog2(DEPTH);
  localparam int EW   = BW + 16;
  localparam int HMAX = (HOLD > HOLD_KON) ? HOLD : HOLD_KON;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_cnt;
  logic [HW-1:0] w_cnt_nxt;
  logic          w_pop;
  logic          w_stb_nxt;

  logic [BW-1:0] r_shadow_bank;
  logic [7:0]    r_shadow_reg;
  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_busy;
  logic          r_stb;
  logic [BW-1:0] r_wr_bank;
  logic [7:0]    r_wr_reg;
  logic [7:0]    r_wr_data;
  logic [CW-1:0] r_ovf;

  logic [BW-1:0] w_addr_bank;
  logic          w_addr_wr;
  logic          w_data_wr;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop;
  logic [LW-1:0] w_level_nxt;
  logic          w_busy_nxt;
  logic [EW-1:0] w_head;

  // Single-bank parts have no bank bits in the address, so the bank is 0.
  generate
    if (AW > 1) begin : g_bank
      assign w_addr_bank = addr[AW-1:1];
    end else begin : g_nobank
      assign w_addr_bank = '0;
    end
  endgenerate

  assign w_addr_wr = write & ~addr[0];
  assign w_data_wr = write & addr[0];
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_head    = r_mem[r_rptr];

  // A push into a full queue is still accepted when the head leaves on the
  // same edge; flush discards a concurrent push without counting it as lost.
  assign w_push = w_data_wr & ~flush & (~w_full | w_pop);
  assign w_drop = w_data_wr & ~flush & w_full & ~w_pop;

  assign w_level_nxt = flush ? '0 : (r_level + LW'(w_push) - LW'(w_pop));
  assign w_busy_nxt  = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);

  // Drain FSM: pop the head when idle, strobe for one cycle, then wait out
  // the hold time (longer after a key-on write) counted in cen ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_stb_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !flush) begin
          w_pop       = 1'b1;
          w_stb_nxt   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = (r_wr_reg == 8'h28) ? HW'(HOLD_KON) : HW'(HOLD);
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else if (cen) begin
          w_cnt_nxt = r_cnt - HW'(1);
          if (r_cnt == HW'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, hold counter and issue outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_stb     <= 1'b0;
      r_wr_bank <= '0;
      r_wr_reg  <= 8'h00;
      r_wr_data <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stb   <= w_stb_nxt;
      r_busy  <= w_busy_nxt;
      if (w_pop) begin
        {r_wr_bank, r_wr_reg, r_wr_data} <= w_head;
      end
    end
  end

  // Shadow address, queue pointers, occupancy and the overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_bank <= '0;
      r_shadow_reg  <= 8'h00;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_level       <= '0;
      r_ovf         <= '0;
    end else begin
      if (w_addr_wr) begin
        r_shadow_bank <= w_addr_bank;
        r_shadow_reg  <= din;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (flush) begin
        r_rptr <= r_wptr;
      end else if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_level <= w_level_nxt;
      if (w_drop && (r_ovf != '1)) begin
        r_ovf <= r_ovf + CW'(1);
      end
    end
  end

  // Queue storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_shadow_bank, r_shadow_reg, din};
    end
  end

  assign busy    = r_busy;
  assign full    = w_full;
  assign empty   = w_empty;
  assign level   = r_level;
  assign wr_stb  = r_stb;
  assign wr_bank = r_wr_bank;
  assign wr_reg  = r_wr_reg;
  assign wr_data = r_wr_data;
  assign ovf_cnt = r_ovf;

endmodule

// File: tb/tb_jt12_mmr_wrq.sv
// tb_jt12_mmr_wrq: scoreboard bench for the queued register write front end.
// Stimulus pushes the hand-computed {bank, reg, data} of every write that
// must be issued; a monitor pops and compares on each wr_stb.
`timescale 1ns/1ps
module tb_jt12_mmr_wrq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic [7:0] din = 8'h00;
  logic [1:0] addr = 2'b00;
  logic       write = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       wr_stb;
  logic [0:0] wr_bank;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic [7:0] ovf_cnt;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lastStrobe = 0;
  int          prevStrobe = 0;
  bit          cenToggle = 1'b0;
  logic [16:0] expQ[$];
  logic [16:0] monExp;

  jt12_mmr_wrq #(
    .DEPTH(8), .BANKS(2), .HOLD(32), .HOLD_KON(64), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr),
    .write(write), .flush(flush), .busy(busy), .full(full),
    .empty(empty), .level(level), .wr_stb(wr_stb), .wr_bank(wr_bank),
    .wr_reg(wr_reg), .wr_data(wr_data), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Cycle count used to measure strobe spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Optional half-rate clock enable.
  always @(negedge clk) if (cenToggle) cen = ~cen;

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      tests++;
      prevStrobe = lastStrobe;
      lastStrobe = cyc;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL strobe: unexpected issue bank=%0d reg=%h data=%h, none required",
                 wr_bank, wr_reg, wr_data);
      end else begin
        monExp = expQ.pop_front();
        if ({wr_bank, wr_reg, wr_data} !== monExp)
          begin
            fails++;
            $display("[TB] FAIL strobe: got bank=%0d reg=%h data=%h, required bank=%0d reg=%h data=%h",
                     wr_bank, wr_reg, wr_data, monExp[16], monExp[15:8], monExp[7:0]);
          end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    din   = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic expectStrobe(input logic b, input logic [7:0] r, input logic [7:0] d);
    expQ.push_back({b, r, d});
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rstLevel", 32'(level), 0);
    checkOutput("rstEmpty", 32'(empty), 1);
    checkOutput("rstFull", 32'(full), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstStb", 32'(wr_stb), 0);
    checkOutput("rstOut", {15'd0, wr_bank, wr_reg, wr_data}, 0);
    checkOutput("rstOvf", 32'(ovf_cnt), 0);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(busy), 0);
  endtask

  initial begin
    int n;
    int d;
    @(negedge clk);
    applyReset();
    checkResetState();

    // Basic write: strobe once, busy for 2 + HOLD cycles.
    expectStrobe(1'b0, 8'h30, 8'h71);
    applyStimulus(2'b00, 8'h30);
    applyStimulus(2'b01, 8'h71);
    checkOutput("pushLevel", 32'(level), 1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busyLen", n, 34);
    checkOutput("holdData", 32'(wr_data), 32'h71);

    // Key-on write holds 64 ticks; next strobe 66 cycles later.
    expectStrobe(1'b0, 8'h28, 8'hF0);
    expectStrobe(1'b0, 8'h40, 8'h11);
    applyStimulus(2'b00, 8'h28);
    applyStimulus(2'b01, 8'hF0);
    applyStimulus(2'b00, 8'h40);
    applyStimulus(2'b01, 8'h11);
    waitIdle(300, "konIdle");
    checkOutput("konSpacing", lastStrobe - prevStrobe, 66);

    // Bank 1 write.
    expectStrobe(1'b1, 8'hA4, 8'h22);
    applyStimulus(2'b10, 8'hA4);
    applyStimulus(2'b11, 8'h22);
    waitIdle(100, "bankIdle");

    // Fill during HOLD: 8 queued, 2 dropped, address port never blocked.
    expectStrobe(1'b1, 8'hA4, 8'h00);
    applyStimulus(2'b11, 8'h00);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) expectStrobe(1'b1, 8'hA4, 8'(i));
      applyStimulus(2'b11, 8'(i));
      if (i == 8) begin
        checkOutput("fullLevel", 32'(level), 8);
        checkOutput("fullFlag", 32'(full), 1);
      end
    end
    checkOutput("ovfTwo", 32'(ovf_cnt), 2);
    checkOutput("dropLevel", 32'(level), 8);
    applyStimulus(2'b00, 8'h55);
    checkOutput("addrWhenFull", 32'(level), 8);
    checkOutput("addrNoOvf", 32'(ovf_cnt), 2);
    waitIdle(500, "drainIdle");
    checkOutput("drainEmpty", 32'(empty), 1);

    // Saturation with the hold frozen by cen=0, then flush.
    expectStrobe(1'b0, 8'h55, 8'hC0);
    applyStimulus(2'b01, 8'hC0);
    repeat (3) @(negedge clk);
    cen = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(2'b01, 8'h80 + 8'(i));
    for (int i = 0; i < 250; i++) applyStimulus(2'b01, 8'hEE);
    checkOutput("ovf252", 32'(ovf_cnt), 252);
    for (int i = 0; i < 10; i++) applyStimulus(2'b01, 8'hEE);
    checkOutput("ovfSat", 32'(ovf_cnt), 255);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("satFlushLevel", 32'(level), 0);
    checkOutput("satFlushBusy", 32'(busy), 1);
    cen = 1'b1;
    waitIdle(100, "satIdle");
    checkOutput("ovfStaySat", 32'(ovf_cnt), 255);

    // Flush at level 5 with a concurrent push during HOLD.
    applyReset();
    checkResetState();
    expectStrobe(1'b0, 8'h10, 8'h01);
    applyStimulus(2'b00, 8'h10);
    applyStimulus(2'b01, 8'h01);
    repeat (3) @(negedge clk);
    for (int i = 2; i <= 6; i++) applyStimulus(2'b01, 8'(i));
    checkOutput("preFlushLevel", 32'(level), 5);
    flush = 1'b1;
    addr  = 2'b01;
    din   = 8'h07;
    write = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    write = 1'b0;
    checkOutput("flushLevel", 32'(level), 0);
    checkOutput("flushEmpty", 32'(empty), 1);
    checkOutput("flushOvf", 32'(ovf_cnt), 0);
    checkOutput("flushBusy", 32'(busy), 1);
    waitIdle(100, "flushIdle");
    checkOutput("flushKeep", 32'(wr_data), 32'h01);

    // Half-rate cen: 32 ticks span 63 or 64 clocks depending on phase,
    // so the spacing is 65 or 66 cycles.
    cenToggle = 1'b1;
    expectStrobe(1'b0, 8'h20, 8'h33);
    expectStrobe(1'b0, 8'h20, 8'h34);
    applyStimulus(2'b00, 8'h20);
    applyStimulus(2'b01, 8'h33);
    applyStimulus(2'b01, 8'h34);
    waitIdle(400, "cenIdle");
    d = lastStrobe - prevStrobe;
    tests++;
    if (d < 65 || d > 66) begin
      fails++;
      $display("[TB] FAIL cenSpacing: got %0d, required 65..66", d);
    end
    cenToggle = 1'b0;
    cen = 1'b1;

    // Reset mid-HOLD discards queued writes and restores the shadow.
    expectStrobe(1'b0, 8'h20, 8'h44);
    applyStimulus(2'b01, 8'h44);
    repeat (3) @(negedge clk);
    applyStimulus(2'b01, 8'h45);
    applyStimulus(2'b01, 8'h46);
    applyReset();
    checkResetState();
    repeat (100) @(negedge clk);
    expectStrobe(1'b0, 8'h00, 8'h99);
    applyStimulus(2'b01, 8'h99);
    waitIdle(100, "shadowIdle");
    checkOutput("sbEmpty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
